// File: rtl/cascade_digit_counter.sv
// Multi-digit cascaded counter for the clock/alarm datapath.
// Each DW-bit digit counts between 0 and its own limit. Up/down steps ripple
// from digit 0 upward. A parallel load clamps each digit to its limit.
// WRAP selects wrap-around or saturation at both ends of the range.
module cascade_digit_counter #(
  parameter int                   DIGITS = 4,
  parameter int                   DW     = 4,
  parameter logic [DIGITS*DW-1:0] LIMITS = 16'h5959,
  parameter logic [DIGITS*DW-1:0] INIT   = 16'h0000,
  parameter bit                   WRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_value,
  output logic [DIGITS*DW-1:0] value,
  output logic                 carry,
  output logic                 borrow,
  output logic                 at_zero
);

  localparam int             VW         = DIGITS * DW;
  localparam logic [DW-1:0]  ZERO_DIGIT = {DW{1'b0}};
  localparam logic [DW-1:0]  ONE_DIGIT  = {{(DW-1){1'b0}}, 1'b1};

  logic [VW-1:0]     value_r;
  logic [VW-1:0]     next_value_s;
  logic [DIGITS-1:0] at_lim_s;
  logic [DIGITS-1:0] is_zero_s;
  logic              all_lim_s;
  logic              all_zero_s;
  logic              up_step_s;
  logic              down_step_s;

  // A loaded digit never exceeds its limit.
  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d,
                                                input logic [DW-1:0] lim);
    if (d > lim) begin
      return lim;
    end else begin
      return d;
    end
  endfunction

  // Per-digit end-of-range flags.
  for (genvar g = 0; g < DIGITS; g++) begin : g_flags
    assign at_lim_s[g]  = (value_r[g*DW +: DW] == LIMITS[g*DW +: DW]);
    assign is_zero_s[g] = (value_r[g*DW +: DW] == ZERO_DIGIT);
  end

  assign all_lim_s   = &at_lim_s;
  assign all_zero_s  = &is_zero_s;

  // Load has priority. Opposing inc/dec and en=0 both mean hold.
  assign up_step_s   = en & inc & ~dec & ~load;
  assign down_step_s = en & dec & ~inc & ~load;

  // Next-state computation. The ripple condition for digit i comes from the chain over digits below it.
  always_comb begin
    logic lim_chain;
    logic zero_chain;
    next_value_s = value_r;
    lim_chain    = 1'b1;
    zero_chain   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load) begin
        next_value_s[i*DW +: DW] = clamp_digit(load_value[i*DW +: DW], LIMITS[i*DW +: DW]);
      end else if (up_step_s && (WRAP || !all_lim_s)) begin
        if (lim_chain) begin
          next_value_s[i*DW +: DW] = at_lim_s[i] ? ZERO_DIGIT
                                                 : value_r[i*DW +: DW] + ONE_DIGIT;
        end else begin
          next_value_s[i*DW +: DW] = value_r[i*DW +: DW];
        end
      end else if (down_step_s && (WRAP || !all_zero_s)) begin
        if (zero_chain) begin
          next_value_s[i*DW +: DW] = is_zero_s[i] ? LIMITS[i*DW +: DW]
                                                  : value_r[i*DW +: DW] - ONE_DIGIT;
        end else begin
          next_value_s[i*DW +: DW] = value_r[i*DW +: DW];
        end
      end else begin
        next_value_s[i*DW +: DW] = value_r[i*DW +: DW];
      end
      lim_chain  = lim_chain & at_lim_s[i];
      zero_chain = zero_chain & is_zero_s[i];
    end
  end

  // Count register. Reset loads INIT asynchronously and discards same-cycle steps and loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r <= INIT;
    end else begin
      value_r <= next_value_s;
    end
  end

  assign value   = value_r;
  // carry and borrow are suppressed while reset is asserted.
  assign carry   = ~reset & up_step_s & all_lim_s;
  assign borrow  = ~reset & down_step_s & all_zero_s;
  assign at_zero = all_zero_s;

endmodule

// File: tb/tb_cascade_digit_counter.sv
// Self-checking bench for cascade_digit_counter.
// One instance wraps and one saturates. Both see the same stimulus.
// The reference treats the counter as a single mixed-radix index.
module tb_cascade_digit_counter;

  localparam int          DIGITS = 4;
  localparam int          DW     = 4;
  localparam logic [15:0] LIMS   = 16'h5959;
  localparam int          TOTAL  = 6 * 10 * 6 * 10;

  logic        clk = 1'b0;
  logic        reset, en, inc, dec, load;
  logic [15:0] load_value;
  logic [15:0] value_w, value_s;
  logic        carry_w, borrow_w, at_zero_w;
  logic        carry_s, borrow_s, at_zero_s;

  int checks   = 0;
  int failures = 0;
  int m_w      = 0;
  int m_s      = 0;

  always #5 clk = ~clk;

  cascade_digit_counter #(.DIGITS(4), .DW(4), .LIMITS(16'h5959), .INIT(16'h0000), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_value(load_value), .value(value_w), .carry(carry_w), .borrow(borrow_w), .at_zero(at_zero_w));

  cascade_digit_counter #(.DIGITS(4), .DW(4), .LIMITS(16'h5959), .INIT(16'h0000), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_value(load_value), .value(value_s), .carry(carry_s), .borrow(borrow_s), .at_zero(at_zero_s));

  function automatic int to_idx(input logic [15:0] v);
    logic [15:0] lim = LIMS;
    int idx = 0;
    int mult = 1;
    for (int i = 0; i < DIGITS; i++) begin
      idx  += int'(v[i*DW +: DW]) * mult;
      mult *= int'(lim[i*DW +: DW]) + 1;
    end
    return idx;
  endfunction

  function automatic logic [15:0] from_idx(input int n);
    logic [15:0] lim = LIMS;
    logic [15:0] v = 16'h0000;
    int r;
    for (int i = 0; i < DIGITS; i++) begin
      r = int'(lim[i*DW +: DW]) + 1;
      v[i*DW +: DW] = 4'(n % r);
      n = n / r;
    end
    return v;
  endfunction

  function automatic logic [15:0] clamp_value(input logic [15:0] v);
    logic [15:0] lim = LIMS;
    logic [15:0] r = 16'h0000;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = (v[i*DW +: DW] > lim[i*DW +: DW]) ? lim[i*DW +: DW] : v[i*DW +: DW];
    end
    return r;
  endfunction

  function automatic bit up_now();
    return en && inc && !dec && !load && !reset;
  endfunction

  function automatic bit down_now();
    return en && dec && !inc && !load && !reset;
  endfunction

  task automatic model_tick();
    if (reset) begin
      m_w = 0;
      m_s = 0;
    end else if (load) begin
      m_w = to_idx(clamp_value(load_value));
      m_s = m_w;
    end else if (up_now()) begin
      m_w = (m_w + 1) % TOTAL;
      m_s = (m_s < TOTAL - 1) ? m_s + 1 : m_s;
    end else if (down_now()) begin
      m_w = (m_w + TOTAL - 1) % TOTAL;
      m_s = (m_s > 0) ? m_s - 1 : 0;
    end
  endtask

  task automatic apply(input bit e, input bit i, input bit d, input bit l, input logic [15:0] lv);
    @(negedge clk);
    en = e; inc = i; dec = d; load = l; load_value = lv;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (value_w !== 16'h0000) begin failures++; $display("FAIL reset_value: got=%h want=%h", value_w, 16'h0000); end
    checks++; if (at_zero_w !== 1'b1) begin failures++; $display("FAIL reset_at_zero: got=%b want=1", at_zero_w); end
    @(negedge clk); reset = 1'b0;
    repeat (12) begin apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); clock_edge(); end
    checks++; if (value_w !== 16'h0012) begin failures++; $display("FAIL count_to_12: got=%h want=%h", value_w, 16'h0012); end
    #2;
    en = 1'b1; inc = 1'b0; dec = 1'b1; reset = 1'b1;
    #1;
    checks++; if (value_w !== 16'h0000) begin failures++; $display("FAIL midcycle_reset_w: got=%h want=%h", value_w, 16'h0000); end
    checks++; if (value_s !== 16'h0000) begin failures++; $display("FAIL midcycle_reset_s: got=%h want=%h", value_s, 16'h0000); end
    checks++; if (carry_w !== 1'b0) begin failures++; $display("FAIL reset_carry: got=%b want=0", carry_w); end
    checks++; if (borrow_w !== 1'b0 || borrow_s !== 1'b0) begin failures++; $display("FAIL reset_borrow: got=%b%b want=00", borrow_w, borrow_s); end
    checks++; if (at_zero_w !== 1'b1) begin failures++; $display("FAIL reset_at_zero2: got=%b want=1", at_zero_w); end
    clock_edge();
    @(negedge clk); reset = 1'b0; en = 1'b1; inc = 1'b1; dec = 1'b0;
    #1;
    checks++; if (value_w !== 16'h0000) begin failures++; $display("FAIL release_no_step: got=%h want=%h", value_w, 16'h0000); end
    clock_edge();
    checks++; if (value_w !== 16'h0001) begin failures++; $display("FAIL first_step_after_release: got=%h want=%h", value_w, 16'h0001); end
  endtask

  task automatic test_up();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0059); clock_edge();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (carry_w !== 1'b0) begin failures++; $display("FAIL up_ripple_carry: got=%b want=0", carry_w); end
    clock_edge();
    checks++; if (value_w !== 16'h0100) begin failures++; $display("FAIL up_ripple: got=%h want=%h", value_w, 16'h0100); end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959); clock_edge();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (carry_w !== 1'b1 || carry_s !== 1'b1) begin failures++; $display("FAIL up_top_carry: got=%b%b want=11", carry_w, carry_s); end
    clock_edge();
    checks++; if (value_w !== 16'h0000) begin failures++; $display("FAIL up_wrap: got=%h want=%h", value_w, 16'h0000); end
    checks++; if (value_s !== 16'h5959) begin failures++; $display("FAIL up_saturate: got=%h want=%h", value_s, 16'h5959); end
  endtask

  task automatic test_down();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100); clock_edge();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (borrow_w !== 1'b0) begin failures++; $display("FAIL down_ripple_borrow: got=%b want=0", borrow_w); end
    clock_edge();
    checks++; if (value_w !== 16'h0059) begin failures++; $display("FAIL down_ripple: got=%h want=%h", value_w, 16'h0059); end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); clock_edge();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (borrow_w !== 1'b1) begin failures++; $display("FAIL down_bottom_borrow: got=%b want=1", borrow_w); end
    clock_edge();
    checks++; if (value_w !== 16'h5959) begin failures++; $display("FAIL down_wrap: got=%h want=%h", value_w, 16'h5959); end
  endtask

  task automatic test_load();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h7A3C);
    checks++; if (carry_w !== 1'b0) begin failures++; $display("FAIL load_carry_en0: got=%b want=0", carry_w); end
    clock_edge();
    checks++; if (value_w !== 16'h5939) begin failures++; $display("FAIL load_clamp: got=%h want=%h", value_w, 16'h5939); end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959); clock_edge();
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h7A3C);
    checks++; if (carry_w !== 1'b0 || carry_s !== 1'b0) begin failures++; $display("FAIL load_over_top_carry: got=%b%b want=00", carry_w, carry_s); end
    clock_edge();
    checks++; if (value_w !== 16'h5939 || value_s !== 16'h5939) begin failures++; $display("FAIL load_priority: got=%h/%h want=%h", value_w, value_s, 16'h5939); end
  endtask

  task automatic test_hold();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234); clock_edge();
    apply(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checks++; if (carry_w !== 1'b0 || borrow_w !== 1'b0) begin failures++; $display("FAIL hold_both_flags: got=%b%b want=00", carry_w, borrow_w); end
    clock_edge();
    checks++; if (value_w !== 16'h1234) begin failures++; $display("FAIL hold_both: got=%h want=%h", value_w, 16'h1234); end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); clock_edge();
    checks++; if (value_w !== 16'h1234) begin failures++; $display("FAIL hold_en0: got=%h want=%h", value_w, 16'h1234); end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959); clock_edge();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (carry_w !== 1'b0) begin failures++; $display("FAIL en0_top_carry: got=%b want=0", carry_w); end
    clock_edge();
    checks++; if (value_w !== 16'h5959) begin failures++; $display("FAIL en0_top_hold: got=%h want=%h", value_w, 16'h5959); end
  endtask

  task automatic test_wrap0();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959); clock_edge();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      checks++; if (carry_s !== 1'b1) begin failures++; $display("FAIL sat_carry_%0d: got=%b want=1", k, carry_s); end
      clock_edge();
      checks++; if (value_s !== 16'h5959) begin failures++; $display("FAIL sat_top_%0d: got=%h want=%h", k, value_s, 16'h5959); end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); clock_edge();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (borrow_s !== 1'b1 || at_zero_s !== 1'b1) begin failures++; $display("FAIL sat_borrow: got=%b%b want=11", borrow_s, at_zero_s); end
    clock_edge();
    checks++; if (value_s !== 16'h0000 || at_zero_s !== 1'b1) begin failures++; $display("FAIL sat_bottom: got=%h/%b want=0000/1", value_s, at_zero_s); end
  endtask

  task automatic test_random();
    logic [15:0] lv;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: lv = 16'($urandom);
        1: lv = 16'h5959;
        2: lv = 16'h0000;
        default: lv = from_idx(int'($urandom_range(0, TOTAL - 1)));
      endcase
      apply(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), lv);
      checks++; if (carry_w !== (up_now() && m_w == TOTAL - 1)) begin failures++; $display("FAIL rnd_carry_w[%0d]: got=%b idx=%0d", n, carry_w, m_w); end
      checks++; if (carry_s !== (up_now() && m_s == TOTAL - 1)) begin failures++; $display("FAIL rnd_carry_s[%0d]: got=%b idx=%0d", n, carry_s, m_s); end
      checks++; if (borrow_w !== (down_now() && m_w == 0)) begin failures++; $display("FAIL rnd_borrow_w[%0d]: got=%b idx=%0d", n, borrow_w, m_w); end
      checks++; if (borrow_s !== (down_now() && m_s == 0)) begin failures++; $display("FAIL rnd_borrow_s[%0d]: got=%b idx=%0d", n, borrow_s, m_s); end
      checks++; if (at_zero_w !== (m_w == 0) || at_zero_s !== (m_s == 0)) begin failures++; $display("FAIL rnd_at_zero[%0d]: got=%b%b idx=%0d/%0d", n, at_zero_w, at_zero_s, m_w, m_s); end
      clock_edge();
      checks++; if (value_w !== from_idx(m_w)) begin failures++; $display("FAIL rnd_value_w[%0d]: got=%h want=%h", n, value_w, from_idx(m_w)); end
      checks++; if (value_s !== from_idx(m_s)) begin failures++; $display("FAIL rnd_value_s[%0d]: got=%h want=%h", n, value_s, from_idx(m_s)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = 16'h0000;
    test_reset();
    test_up();
    test_down();
    test_load();
    test_hold();
    test_wrap0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cascade_digit_counter.md
Name: cascade_digit_counter

Overview:
Parametrised multi-digit cascaded counter for the clock/alarm datapath. Replaces per-digit instances with one block of DIGITS digits, each with its own limit. Supports up count, down count, parallel load with clamping, and a wrap or saturate mode. Drives the time/alarm display digits and provides carry/borrow for chaining further blocks.

Parameters:
DIGITS, 4, number of cascaded digits; digit 0 is least significant.
DW, 4, bits per digit.
LIMITS, 16'h5959, packed per-digit maximum value; digit i is bits [i*DW +: DW].
INIT, 16'h0000, packed reset value per digit; every field must be no greater than its limit.
WRAP, 1, 1 = wrap around at the ends; 0 = saturate at the ends.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; loads INIT.
en  in  1  count enable; gates inc/dec only, not load.
inc  in  1  count up one step this cycle.
dec  in  1  count down one step this cycle.
load  in  1  parallel load of load_value.
load_value  in  DIGITS*DW  packed digits to load.
value  out  DIGITS*DW  registered packed count.
carry  out  1  combinational; up step taken while every digit equals its limit.
borrow  out  1  combinational; down step taken while every digit is zero.
at_zero  out  1  combinational; all digits zero.

Behaviour:
- reset=1: value=INIT immediately, without waiting for a clock edge. While reset is high, carry=0 and borrow=0, and at_zero follows INIT. On reset release, no count or load happens until the next clk edge.
- Per-cycle priority: load > up step > down step > hold.
- up step = en & inc & ~dec & ~load.
- down step = en & dec & ~inc & ~load.
- inc and dec both high: hold; carry=0, borrow=0.
- en=0: hold; carry=0, borrow=0, whatever inc/dec are.
- Load: each digit gets min(load_value field, its LIMITS field) on the next edge. load ignores en. carry=0 and borrow=0 during a load cycle.
- Up step ripple:
  - digit 0 always steps.
  - digit i steps only if digits 0..i-1 all equal their limits.
  - a stepping digit at its limit goes to 0; otherwise it goes to +1.
- Down step ripple:
  - digit i steps only if digits 0..i-1 are all 0.
  - a stepping digit at 0 goes to its limit; otherwise it goes to -1.
- carry = up step & all digits at limit, in the same cycle, before the edge.
  - WRAP=1: value becomes all zeros on the edge.
  - WRAP=0: value holds at all-limit; carry still pulses each attempted cycle.
- borrow = down step & all digits zero.
  - WRAP=1: value becomes all-limit on the edge.
  - WRAP=0: value holds at zero; borrow still pulses.
- Single-step latency: value updates on the clk edge after the qualifying cycle. carry, borrow and at_zero are combinational from the current value and inputs.
- Arithmetic is per digit, in DW bits, with no binary carry between fields. A digit can never hold a value above its limit.
- Reset mid-count overrides everything. A load or step in the same cycle as reset is discarded.

Test Plan:
All scenarios use DIGITS=4, DW=4, LIMITS=16'h5959, INIT=16'h0000, WRAP=1 unless stated.
1. Reset: count to 16'h0012, then raise reset between edges -> value=16'h0000 at once; carry=0, borrow=0, at_zero=1.
2. Up count:
   - value=16'h0059, en=1, inc=1 for one cycle -> 16'h0100.
   - value=16'h5959, inc=1 -> carry=1 that cycle, value=16'h0000 next edge.
3. Down count:
   - value=16'h0100, dec=1 -> 16'h0059.
   - value=16'h0000, dec=1 -> borrow=1 that cycle, value=16'h5959 next edge.
4. Load with clamping: load=1, load_value=16'h7A3C, inc=1, en=0 -> value=16'h5939 (digits 7→5, A→9, C→9). carry=0, and no increment is applied.
5. Hold cases:
   - inc=1 and dec=1, en=1, from 16'h1234 -> value stays 16'h1234; carry=0, borrow=0.
   - en=0, inc=1 -> value holds.
6. WRAP=0:
   - 16'h5959 with inc=1 for 3 cycles -> value stays 16'h5959; carry=1 in each cycle.
   - 16'h0000 with dec=1 -> value stays 16'h0000; borrow=1, at_zero=1.
